// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU writeback stage.
// Op codes, flag bit positions and the buffered result entry.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_L = 3;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] dest;
  } wb_entry_t;

  function automatic logic [3:0] calc_flags(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] r
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[DATA_W-1];
    f[FLAG_P] = ^r;
    f[FLAG_L] = (op == OP_AND) || (op == OP_OR) ||
                (op == OP_XOR) || (op == OP_NOT);
    return f;
  endfunction

endpackage

// File: rtl/alu_writeback_fifo.sv
// Pending-result FIFO for the writeback stage.
// Exposes every slot with a valid bit so the top can detect hazards.
module wb_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t [DEPTH-1:0]    slots,
  output logic [DEPTH-1:0]         slot_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign dout     = mem_q[rd_q];
  assign slots    = mem_q;
  assign slot_vld = vld_q;

  // Full is judged on current occupancy; a same-cycle pop does not free a slot.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + AW'(1);
    end
    if (do_push) begin
      mem_d[wr_q] = din;
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + AW'(1);
    end
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: buffers results, commits one per cycle into the
// register file, maintains flags and reports read-port hazards.
module alu_writeback #(
  parameter int DATA_W     = 8,
  parameter int REG_CNT    = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_op,
  input  logic [DATA_W-1:0]             in_result,
  input  logic [$clog2(REG_CNT)-1:0]    in_dest,
  input  logic                          ld_en,
  input  logic [$clog2(REG_CNT)-1:0]    ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  input  logic [$clog2(REG_CNT)-1:0]    rd_addr_a,
  input  logic [$clog2(REG_CNT)-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]             rd_data_a,
  output logic [DATA_W-1:0]             rd_data_b,
  output logic                          hazard_a,
  output logic                          hazard_b,
  output logic [3:0]                    flags,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  import alu_pkg::*;

  logic [DATA_W-1:0]          regs_q [REG_CNT];
  logic [DATA_W-1:0]          regs_d [REG_CNT];
  logic [3:0]                 flags_q, flags_d;
  wb_entry_t                  push_ent;
  wb_entry_t                  head;
  wb_entry_t [FIFO_DEPTH-1:0] slots;
  logic [FIFO_DEPTH-1:0]      slot_vld;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       do_pop;

  assign push_ent = '{op: in_op, result: in_result, dest: in_dest};
  assign in_ready = !fifo_full;
  // Loads own the write port outright, so the drain waits for them.
  assign do_pop   = !fifo_empty && !ld_en;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid && in_ready),
    .pop      (do_pop),
    .din      (push_ent),
    .dout     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (pending),
    .slots    (slots),
    .slot_vld (slot_vld)
  );

  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    if (ld_en) begin
      regs_d[ld_addr] = ld_data;
    end else if (do_pop && head.op != OP_NOP) begin
      regs_d[head.dest] = head.result;
      flags_d           = calc_flags(head.op, head.result);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++)
        regs_q[i] <= '0;
      flags_q <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++)
        regs_q[i] <= regs_d[i];
      flags_q <= flags_d;
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign flags     = flags_q;

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld[i] && slots[i].op != OP_NOP) begin
        if (slots[i].dest == rd_addr_a) hazard_a = 1'b1;
        if (slots[i].dest == rd_addr_b) hazard_b = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table plus
// hand-written full/stall and mid-stream reset sequences.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_result;
  logic [2:0] in_dest;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [2:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       hazard_a, hazard_b;
  logic [3:0] flags;
  logic [1:0] pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_result (in_result),
    .in_dest   (in_dest),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .flags     (flags),
    .pending   (pending)
  );

  typedef struct {
    logic       ld;
    logic [2:0] la;
    logic [7:0] ldd;
    logic       v;
    logic [3:0] op;
    logic [7:0] res;
    logic [2:0] dst;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [3:0] e_f;
    logic [1:0] e_p;
    logic       e_rdy;
    logic       e_ha;
    logic       e_hb;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_result = 8'h00;
    in_dest   = 3'd0;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] r,
                      input logic [2:0] d);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = r;
    in_dest   = d;
  endtask

  initial begin
    // ld la ldd v op res dst ra rb | e_a e_b e_f e_p rdy ha hb
    vecs[0]  = '{1'b0, 3'd0, 8'h00, 1'b1, 4'h3, 8'h00, 3'd2, 3'd2, 3'd0,
                 8'h00, 8'h00, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00, 3'd0, 3'd2, 3'd0,
                 8'h00, 8'h00, 4'b1001, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd5, 8'h3C, 1'b1, 4'h5, 8'h81, 3'd5, 3'd5, 3'd0,
                 8'h3C, 8'h00, 4'b1001, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'd5, 8'h3C, 1'b0, 4'h0, 8'h00, 3'd0, 3'd5, 3'd0,
                 8'h3C, 8'h00, 4'b1001, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00, 3'd0, 3'd5, 3'd0,
                 8'h81, 8'h00, 4'b1010, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 4'hF, 8'hFF, 3'd1, 3'd1, 3'd0,
                 8'h00, 8'h00, 4'b1010, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00, 3'd0, 3'd1, 3'd0,
                 8'h00, 8'h00, 4'b1010, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 4'h0, 8'h7F, 3'd0, 3'd0, 3'd5,
                 8'h00, 8'h81, 4'b1010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00, 3'd0, 3'd0, 3'd5,
                 8'h7F, 8'h81, 4'b0100, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 4'h4, 8'h12, 3'd3, 3'd3, 3'd4,
                 8'h00, 8'h00, 4'b0100, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 4'h6, 8'hFE, 3'd4, 3'd3, 3'd4,
                 8'h12, 8'h00, 4'b1000, 2'd1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00, 3'd0, 3'd3, 3'd4,
                 8'h12, 8'hFE, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    idle_in();
    ld_en     = 1'b0;
    ld_addr   = 3'd0;
    ld_data   = 8'h00;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    step();
    step();
    chk("rst_pending", pending, 2'd0);
    chk("rst_ready",   in_ready, 1'b1);
    chk("rst_flags",   flags, 4'b0000);
    chk("rst_rd_a",    rd_data_a, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      ld_en     = vecs[i].ld;
      ld_addr   = vecs[i].la;
      ld_data   = vecs[i].ldd;
      in_valid  = vecs[i].v;
      in_op     = vecs[i].op;
      in_result = vecs[i].res;
      in_dest   = vecs[i].dst;
      rd_addr_a = vecs[i].ra;
      rd_addr_b = vecs[i].rb;
      step();
      chk($sformatf("v%0d_rd_a", i),  rd_data_a, vecs[i].e_a);
      chk($sformatf("v%0d_rd_b", i),  rd_data_b, vecs[i].e_b);
      chk($sformatf("v%0d_flags", i), flags,     vecs[i].e_f);
      chk($sformatf("v%0d_pend", i),  pending,   vecs[i].e_p);
      chk($sformatf("v%0d_ready", i), in_ready,  vecs[i].e_rdy);
      chk($sformatf("v%0d_haz_a", i), hazard_a,  vecs[i].e_ha);
      chk($sformatf("v%0d_haz_b", i), hazard_b,  vecs[i].e_hb);
    end

    // Full FIFO under a sustained load: nothing lost, order kept.
    ld_en     = 1'b1;
    ld_addr   = 3'd7;
    ld_data   = 8'h55;
    rd_addr_a = 3'd7;
    rd_addr_b = 3'd6;
    push(4'h4, 8'h11, 3'd6);
    step();
    chk("full_pend1",  pending, 2'd1);
    chk("full_ready1", in_ready, 1'b1);
    push(4'h4, 8'h22, 3'd7);
    step();
    chk("full_pend2",  pending, 2'd2);
    chk("full_ready0", in_ready, 1'b0);
    push(4'h4, 8'h33, 3'd6);
    #1;
    chk("full_ready_pre", in_ready, 1'b0);
    step();
    chk("full_pend_hold", pending, 2'd2);
    chk("full_ld_reg7",   rd_data_a, 8'h55);
    chk("full_flags_ld",  flags, 4'b1110);
    idle_in();
    step();
    chk("full_pend_hold2", pending, 2'd2);
    chk("full_haz_b",      hazard_b, 1'b1);
    ld_en     = 1'b0;
    rd_addr_a = 3'd6;
    rd_addr_b = 3'd7;
    step();
    chk("drain1_reg6",  rd_data_a, 8'h11);
    chk("drain1_pend",  pending, 2'd1);
    chk("drain1_ready", in_ready, 1'b1);
    chk("drain1_flags", flags, 4'b1000);
    chk("drain1_haz_b", hazard_b, 1'b1);
    chk("drain1_haz_a", hazard_a, 1'b0);
    step();
    chk("drain2_reg7",  rd_data_b, 8'h22);
    chk("drain2_pend",  pending, 2'd0);
    chk("drain2_haz_b", hazard_b, 1'b0);
    step();
    chk("drain3_reg6",  rd_data_a, 8'h11);

    // Mid-stream reset discards held entries and clears state.
    ld_en   = 1'b1;
    ld_addr = 3'd1;
    ld_data = 8'h99;
    rd_addr_a = 3'd1;
    rd_addr_b = 3'd2;
    push(4'h0, 8'h0A, 3'd2);
    step();
    push(4'h0, 8'h0B, 3'd3);
    step();
    chk("prerst_pend", pending, 2'd2);
    chk("prerst_reg1", rd_data_a, 8'h99);
    idle_in();
    ld_en = 1'b0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_pend",  pending, 2'd0);
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_flags", flags, 4'b0000);
    chk("mrst_reg1",  rd_data_a, 8'h00);
    chk("mrst_haz_b", hazard_b, 1'b0);
    step();
    rd_addr_a = 3'd3;
    #1;
    chk("mrst_reg2", rd_data_b, 8'h00);
    chk("mrst_reg3", rd_data_a, 8'h00);
    chk("mrst_pend2", pending, 2'd0);
    rd_addr_a = 3'd4;
    #1;
    chk("mrst_reg4", rd_data_a, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
